// File: rtl/pre_i_mode_pkg.sv
// Shared types and constants for the pre-intra mode buffer and its address mapper.
// Address layout per bank: 0..63 8x8, 64..79 16x16, 80..83 32x32, all in z-order.
package pre_i_mode_pkg;

    localparam int MODE_W  = 6;
    localparam int ADDR_W  = 7;
    localparam int MODE_DC = 1;

    typedef enum logic [1:0] {
        SZ8   = 2'd0,
        SZ16  = 2'd1,
        SZ32  = 2'd2,
        SZRSV = 2'd3
    } rd_size_e;

    localparam logic [ADDR_W-1:0] BASE16 = 7'd64;
    localparam logic [ADDR_W-1:0] BASE32 = 7'd80;

endpackage

// File: rtl/pre_i_mode_addr.sv
// Maps a block size and 4x4 coordinate inside the LCU to a mode-RAM address.
// Purely combinational; o_vld is low for the reserved size code.
module pre_i_mode_addr
    import pre_i_mode_pkg::*;
(
    input  logic [1:0]        i_size,
    input  logic [3:0]        i_x,
    input  logic [3:0]        i_y,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_vld
);

    logic [5:0] w_z8;
    logic [3:0] w_z16;
    logic [1:0] w_z32;

    // Bit 0 of each coordinate selects a 4x4 inside its 8x8 parent and is dropped.
    assign w_z8  = {i_y[3], i_x[3], i_y[2], i_x[2], i_y[1], i_x[1]};
    assign w_z16 = {i_y[3], i_x[3], i_y[2], i_x[2]};
    assign w_z32 = {i_y[3], i_x[3]};

    always_comb begin
        o_addr = '0;
        o_vld  = 1'b1;
        case (rd_size_e'(i_size))
            SZ8:     o_addr = {1'b0, w_z8};
            SZ16:    o_addr = BASE16 + {3'b000, w_z16};
            SZ32:    o_addr = BASE32 + {5'b00000, w_z32};
            default: o_vld  = 1'b0;
        endcase
    end

endmodule

// File: rtl/pre_i_mode_buf.sv
// Ping-pong mode buffer: one bank captures the current LCU's modes, the other serves reads.
// Read latency 1 cycle; writes and wr_done are dropped (sticky ovf_o) when no bank is free.
module pre_i_mode_buf
    import pre_i_mode_pkg::*;
#(
    parameter int MODE_W_P = MODE_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int DEF_MODE = MODE_DC
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                md_we,
    input  logic [ADDR_W_P-1:0] md_waddr,
    input  logic [MODE_W_P-1:0] md_wdata,
    input  logic                wr_done_i,
    output logic                wr_ready_o,
    output logic                rd_valid_o,
    input  logic                rd_en_i,
    input  logic [1:0]          rd_size_i,
    input  logic [3:0]          rd_x_i,
    input  logic [3:0]          rd_y_i,
    input  logic                rd_done_i,
    output logic [MODE_W_P-1:0] rd_mode_o,
    output logic                rd_mode_vld_o,
    output logic                ovf_o
);

    localparam int DEPTH = 1 << ADDR_W_P;

    logic [MODE_W_P-1:0] r_mem [2][DEPTH];
    logic [DEPTH-1:0]    r_bmp [2];
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [MODE_W_P-1:0] r_mode;
    logic                r_mode_vld;
    logic                r_ovf;

    logic                w_wr_ready;
    logic                w_rd_valid;
    logic                w_wr_acc;
    logic                w_wr_fin;
    logic                w_rd_rel;
    logic [1:0]          w_full_nxt;
    logic [ADDR_W-1:0]   w_raddr;
    logic                w_raddr_vld;
    logic                w_hit;

    assign w_wr_ready = !r_full[r_wr_bank];
    assign w_rd_valid = r_full[r_rd_bank];
    assign w_wr_acc   = md_we & w_wr_ready;
    assign w_wr_fin   = wr_done_i & w_wr_ready;
    assign w_rd_rel   = rd_done_i & w_rd_valid;

    pre_i_mode_addr u_addr (
        .i_size (rd_size_i),
        .i_x    (rd_x_i),
        .i_y    (rd_y_i),
        .o_addr (w_raddr),
        .o_vld  (w_raddr_vld)
    );

    // A finishing write bank is empty and a releasing read bank is full, so they never coincide.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_fin) w_full_nxt[r_wr_bank] = 1'b1;
        if (w_rd_rel) w_full_nxt[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_fin) r_wr_bank <= ~r_wr_bank;
            if (w_rd_rel) r_rd_bank <= ~r_rd_bank;
            if ((md_we || wr_done_i) && !w_wr_ready) r_ovf <= 1'b1;
        end
    end

    // Data array carries no reset; the written bitmap alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_bank][md_waddr] <= md_wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bmp[0] <= '0;
            r_bmp[1] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_rd_rel && (r_rd_bank == 1'(b)))
                    r_bmp[b] <= '0;
                else if (w_wr_acc && (r_wr_bank == 1'(b)))
                    r_bmp[b][md_waddr] <= 1'b1;
            end
        end
    end

    assign w_hit = w_rd_valid & w_raddr_vld & r_bmp[r_rd_bank][w_raddr];

    // Reads sample the pre-toggle read bank, so a read alongside rd_done_i still sees the old LCU.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode     <= MODE_W_P'(DEF_MODE);
            r_mode_vld <= 1'b0;
        end else begin
            r_mode_vld <= rd_en_i;
            if (rd_en_i)
                r_mode <= w_hit ? r_mem[r_rd_bank][w_raddr] : MODE_W_P'(DEF_MODE);
        end
    end

    assign wr_ready_o    = w_wr_ready;
    assign rd_valid_o    = w_rd_valid;
    assign rd_mode_o     = r_mode;
    assign rd_mode_vld_o = r_mode_vld;
    assign ovf_o         = r_ovf;

endmodule

// File: doc/pre_i_mode_buf.md
Name: pre_i_mode_buf

Overview:
- Ping-pong mode buffer on the consumer side of the pre-intra mode-RAM write port (md_we/md_waddr/md_wdata).
- Captures one LCU's best modes (8x8, 16x16 and 32x32) per bank while the intra-prediction stage reads the previous LCU's modes from the other bank by block size and 4x4 coordinate.
- Bank ownership is handed over with done pulses from each side.

Parameters:
- MODE_W, 6, width of one stored mode.
- ADDR_W, 7, mode write address width; 128 entries per bank.
- DEF_MODE, 1, mode returned for unwritten entries or reads with no valid bank (DC).

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- md_we  input  1  mode write strobe from the pre-intra mode decision
- md_waddr  input  7  write address; 0..63 = 8x8 in z-order, 64..79 = 16x16 in z-order, 80..83 = 32x32 in z-order
- md_wdata  input  6  mode value
- wr_done_i  input  1  pulse: current write bank complete (driven by pre-intra finish)
- wr_ready_o  output  1  write bank is free to accept writes
- rd_valid_o  output  1  read bank holds a complete LCU
- rd_en_i  input  1  read request
- rd_size_i  input  2  0 = 8x8 (4x4 reads use the parent 8x8), 1 = 16x16, 2 = 32x32, 3 = reserved
- rd_x_i  input  4  4x4 column inside the LCU
- rd_y_i  input  4  4x4 row inside the LCU
- rd_done_i  input  1  pulse: consumer has finished the read bank
- rd_mode_o  output  6  mode read result
- rd_mode_vld_o  output  1  rd_mode_o valid, one-cycle pulse
- ovf_o  output  1  sticky: write dropped or wr_done while no free bank

Behaviour:
- Reset: clk domain; rstn is asynchronous and active-low.
  - Outputs after reset: wr_ready_o = 1, rd_valid_o = 0, rd_mode_o = DEF_MODE, rd_mode_vld_o = 0, ovf_o = 0.
  - Internal state after reset: wr_bank = 0, rd_bank = 0, full[1:0] = 0, valid bitmaps cleared.
  - Reset mid-LCU discards all contents.
- Storage: 2 banks x 128 x MODE_W, plus a per-bank 128-bit written bitmap.
- Write path:
  - When md_we = 1 and wr_ready_o = 1: store md_wdata at [wr_bank][md_waddr] and set the bitmap bit. A rewrite of the same address overwrites.
  - When md_we = 1 and wr_ready_o = 0: drop the write and set ovf_o.
- wr_ready_o = !full[wr_bank].
- On wr_done_i with wr_ready_o = 1: set full[wr_bank] and toggle wr_bank.
- On wr_done_i with wr_ready_o = 0: ignore it and set ovf_o.
- rd_valid_o = full[rd_bank].
- On rd_done_i with rd_valid_o = 1: clear full[rd_bank] and its bitmap, then toggle rd_bank. rd_done_i with rd_valid_o = 0 is ignored.
- Simultaneous wr_done_i and rd_done_i: both take effect in the same cycle. Each side's bank pointer and full bit update independently; full of different banks never conflicts.
- A write to a bank and wr_done_i in the same cycle: the write lands before the bank is marked full.
- Read address mapping:
  - size 0: {y3,x3,y2,x2,y1,x1}
  - size 1: 64 + {y3,x3,y2,x2}
  - size 2: 80 + {y3,x3}
- Read latency: 1 cycle. rd_mode_vld_o is asserted the cycle after rd_en_i.
  - rd_mode_o = stored value if rd_valid_o = 1 and the bitmap bit is set; otherwise DEF_MODE.
  - size 3 always returns DEF_MODE.
  - rd_mode_o holds its value between reads.
- The read bank is never written; the write bank is never read. Entries 84..127 are writable and count toward the bitmap but are unreachable by reads.
- A read issued in the same cycle as rd_done_i uses the bank before the toggle.

Decomposition:
- Shared package: MODE_DC = 1, the size codes (SZ8 = 0, SZ16 = 1, SZ32 = 2), and the address bases (BASE16 = 64, BASE32 = 80).
- One sub-module: pre_i_mode_addr, the combinational size/x/y to 7-bit address mapper. It is reused by intra-prediction consumers.
- Bank storage is a 2p register array inferred in-module.

Test Plan:
- Reset, then write addr 0..83 with mode = addr % 35, then wr_done. Expect rd_valid_o = 1 and wr_ready_o = 1.
  - size 0, x = 2, y = 2 returns mode 3.
  - size 1, x = 4, y = 0 returns 65 % 35 = 30.
  - size 2, x = 8, y = 8 returns 83 % 35 = 13.
  - Each result appears one cycle after rd_en_i.
- Fill bank 0 and wr_done, then fill bank 1 and wr_done. Expect wr_ready_o = 0. A further md_we sets ovf_o = 1 and the data is not stored. After rd_done, wr_ready_o returns to 1.
- Write only addr 5 = 20, then wr_done. A read at the size-0 coordinate mapping to 5 returns 20; a read mapping to 6 returns 1; a size 3 read returns 1.
- Read before any wr_done (rd_valid_o = 0). Expect rd_mode_o = 1 with rd_mode_vld_o pulsing.
- Issue wr_done_i and rd_done_i in the same cycle with one bank full. Expect the full count unchanged, both pointers toggled, and a correct mode readback from the newly full bank.
- Assert rstn low mid-write with a bank full. Expect all flags cleared, wr_ready_o = 1, rd_valid_o = 0, and ovf_o = 0.
